// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU.
//   - alucontrol operation codes (ALU_AND/OR/ADD/SUB/SLT)
//   - controller state encoding
//   - is_legal_op(): true for the five implemented codes
//   - needs_carry_in(): true for ops computed as A + ~B + 1
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: is_legal_op = 1'b1;
      default:                                    is_legal_op = 1'b0;
    endcase
  endfunction

  // Subtraction and set-less-than both evaluate A + ~B + 1.
  function automatic logic needs_carry_in(input logic [2:0] op);
    needs_carry_in = (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_digit_slice.sv
// Combinational DIGIT-bit slice of the serial ALU.
// Ports:
//   a, b     : DIGIT-bit operand digits
//   op       : alucontrol code (only legal codes are ever presented)
//   cin      : carry into the digit
//   res      : digit result (sum or bitwise result)
//   cout     : carry out of the digit msb
//   msb_cin  : carry into the digit msb; with cout it gives signed overflow
module alu_digit_slice
  import alu_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic [DIGIT-1:0] res,
  output logic             cout,
  output logic             msb_cin
);

  logic [DIGIT-1:0] b_eff;
  logic [DIGIT:0]   sum;

  // op[2] marks the subtracting codes (sub, slt).
  assign b_eff = op[2] ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cin};

  assign cout    = sum[DIGIT];
  // Carry into the msb recovered from the msb sum bit: s = a ^ b ^ c.
  assign msb_cin = a[DIGIT-1] ^ b_eff[DIGIT-1] ^ sum[DIGIT-1];

  always_comb begin
    res = sum[DIGIT-1:0];
    case (op)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      default: res = sum[DIGIT-1:0];
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Iterative digit-serial ALU. Latches a, b and alucontrol on an accepted
// start, then processes DIGIT bits per cycle, LSB first, over N=WIDTH/DIGIT
// cycles, and reports result/zero/err with a one-cycle done pulse.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-low reset
//   start      : request, accepted whenever busy=0 (IDLE or DONE)
//   alucontrol : 010 add, 110 sub, 000 and, 001 or, 111 slt; others illegal
//   a, b       : operands, sampled only in the start-accept cycle
//   busy       : high while the digit loop runs
//   done       : one-cycle pulse, result/zero/err valid in that cycle
//   result     : registered result, held between done pulses
//   zero, err  : result==0 and illegal-code flags, updated with done
// Handshake: start is a single-cycle request qualified by busy=0; a start
// seen while busy=1 is dropped, and each accepted start yields exactly one
// done pulse unless reset aborts it first.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;

  logic [DIGIT-1:0]       d_res;
  logic                   d_cout;
  logic                   d_msb_cin;
  logic [WIDTH+DIGIT-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_next;
  logic                   slt_bit;
  logic [WIDTH-1:0]       final_result;

  // Operands are shifted right each cycle so the current digit is always
  // in the low DIGIT bits; this equals selecting bits [k*DIGIT +: DIGIT].
  alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a       (a_sh[DIGIT-1:0]),
    .b       (b_sh[DIGIT-1:0]),
    .op      (op_q),
    .cin     (carry),
    .res     (d_res),
    .cout    (d_cout),
    .msb_cin (d_msb_cin)
  );

  // New digit enters at the top; after N shifts digit 0 sits at bit 0.
  assign acc_cat  = {d_res, acc};
  assign acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];

  // Only meaningful on the last digit: sign of A-B corrected by signed
  // overflow (carry into msb XOR carry out) gives the true signed A<B.
  assign slt_bit = d_res[DIGIT-1] ^ (d_msb_cin ^ d_cout);

  assign final_result = (op_q == ALU_SLT) ? {{(WIDTH-1){1'b0}}, slt_bit}
                                          : acc_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      err    <= 1'b0;
      cnt    <= '0;
      carry  <= 1'b0;
      op_q   <= ALU_AND;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE (back-to-back).
        ST_IDLE, ST_DONE: begin
          if (start && is_legal_op(alucontrol)) begin
            op_q  <= alucontrol;
            a_sh  <= a;
            b_sh  <= b;
            acc   <= '0;
            cnt   <= '0;
            carry <= needs_carry_in(alucontrol);
            busy  <= 1'b1;
            state <= ST_RUN;
          end else if (start) begin
            result <= '0;
            zero   <= 1'b1;
            err    <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_DONE;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc   <= acc_next;
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= d_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= final_result;
            zero   <= (final_result == '0);
            err    <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial (WIDTH=32, DIGIT=4, N=8). Inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_alu_serial;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       alucontrol = 3'b000;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             err;

  int total = 0;
  int bad   = 0;

  alu_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .zero       (zero),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Presents one start (called 1 unit after an edge), waits for done.
  // edges = rising edges after the accept edge E0 until done is seen,
  // so a legal op gives N and an illegal op gives 0.
  task automatic run_op(input logic [2:0] op, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, output int edges,
                        output int busy_cycles, output logic timed_out);
    alucontrol = op;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    edges = 0;
    busy_cycles = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      edges++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    // A start during reset must be ignored.
    reset = 1'b0;
    start = 1'b1;
    alucontrol = OP_ADD;
    a = 32'd1;
    b = 32'd2;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", zero); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_add();
    int e, bc;
    logic to;
    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, e, bc, to);
    total++; if (to) begin bad++; $display("FAIL add_timeout got=no_done want=done"); end
    total++; if (e !== N) begin bad++; $display("FAIL add_latency got=%0d want=%0d", e, N); end
    total++; if (bc !== N) begin bad++; $display("FAIL add_busy_cycles got=%0d want=%0d", bc, N); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_busy_in_done got=%b want=0", busy); end
    total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL add_result got=%h want=80000000", result); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL add_zero got=%b want=0", zero); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL add_err got=%b want=0", err); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%b want=0", done); end
    total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL add_result_hold got=%h want=80000000", result); end
  endtask

  task automatic test_back_to_back();
    int e, bc;
    logic to;
    run_op(OP_SUB, 32'd5, 32'd5, e, bc, to);
    total++; if (to) begin bad++; $display("FAIL sub1_timeout got=no_done want=done"); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL sub1_result got=%h want=0", result); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL sub1_zero got=%b want=1", zero); end
    // Still in the DONE cycle: issue the next start immediately.
    run_op(OP_SUB, 32'd3, 32'd5, e, bc, to);
    total++; if (to) begin bad++; $display("FAIL sub2_timeout got=no_done want=done"); end
    total++; if (e !== N) begin bad++; $display("FAIL sub2_latency got=%0d want=%0d", e, N); end
    total++; if (result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub2_result got=%h want=fffffffe", result); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL sub2_zero got=%b want=0", zero); end
  endtask

  task automatic test_slt();
    int e, bc;
    logic to;
    run_op(OP_SLT, 32'h8000_0000, 32'h0000_0001, e, bc, to);
    total++; if (to) begin bad++; $display("FAIL slt1_timeout got=no_done want=done"); end
    total++; if (result !== 32'h1) begin bad++; $display("FAIL slt1_result got=%h want=1", result); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL slt1_zero got=%b want=0", zero); end
    @(posedge clk); #1;
    // 0x7FFFFFFF - (-1) overflows; signed compare is still false.
    run_op(OP_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, e, bc, to);
    total++; if (to) begin bad++; $display("FAIL slt2_timeout got=no_done want=done"); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL slt2_result got=%h want=0", result); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL slt2_zero got=%b want=1", zero); end
  endtask

  task automatic test_logic();
    int e, bc;
    logic to;
    run_op(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, e, bc, to);
    total++; if (to) begin bad++; $display("FAIL and_timeout got=no_done want=done"); end
    total++; if (result !== 32'h00F0_00F0) begin bad++; $display("FAIL and_result got=%h want=00f000f0", result); end
    @(posedge clk); #1;
    run_op(OP_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, e, bc, to);
    total++; if (to) begin bad++; $display("FAIL or_timeout got=no_done want=done"); end
    total++; if (result !== 32'hFFF0_FFF0) begin bad++; $display("FAIL or_result got=%h want=fff0fff0", result); end
    total++; if (e !== N) begin bad++; $display("FAIL or_latency got=%0d want=%0d", e, N); end
  endtask

  task automatic test_illegal();
    int e, bc;
    logic to;
    @(posedge clk); #1;
    run_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, e, bc, to);
    total++; if (to) begin bad++; $display("FAIL ill_timeout got=no_done want=done"); end
    total++; if (e !== 0) begin bad++; $display("FAIL ill_latency got=%0d want=0", e); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_err got=%b want=1", err); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL ill_result got=%h want=0", result); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL ill_zero got=%b want=1", zero); end
    @(posedge clk); #1;
    run_op(OP_ADD, 32'd1, 32'd1, e, bc, to);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ill_err_clear got=%b want=0", err); end
    total++; if (result !== 32'd2) begin bad++; $display("FAIL ill_next_result got=%h want=2", result); end
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    @(posedge clk); #1;
    alucontrol = OP_ADD;
    a = 32'd100;
    b = 32'd200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmr_busy got=%b want=0", busy); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL rmr_result got=%h want=0", result); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rmr_done got=%b want=0", done); end
    reset = 1'b1;
    seen = 1'b0;
    repeat (2 * N) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmr_no_done got=%b want=0", seen); end
  endtask

  task automatic test_start_ignored();
    int e;
    alucontrol = OP_ADD;
    a = 32'd10;
    b = 32'd20;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0;
    repeat (3) begin @(posedge clk); #1; e++; end
    alucontrol = OP_SUB;
    a = 32'd1000;
    b = 32'd7;
    start = 1'b1;
    @(posedge clk); #1;
    e++;
    start = 1'b0;
    while (!done && e < 40) begin @(posedge clk); #1; e++; end
    total++; if (!done) begin bad++; $display("FAIL ign_timeout got=no_done want=done"); end
    total++; if (e !== N) begin bad++; $display("FAIL ign_latency got=%0d want=%0d", e, N); end
    total++; if (result !== 32'd30) begin bad++; $display("FAIL ign_result got=%h want=1e", result); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_no_restart got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    @(posedge clk); #1;
    test_slt();
    @(posedge clk); #1;
    test_logic();
    test_illegal();
    test_reset_mid_run();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
